frame_streamer: RTL and testbench
=================================

Name: frame_streamer

Overview:
- Parametrised successor of the 7-segment digit streamer.
- Streams a complete 128xN OLED frame, column-major, to the OLED driver: blank left margin, DIGITS_NUM glyph fields, blank right margin, then a sync strobe.
- Adds leading-zero blanking, frame inversion, configurable margin and geometry.
- Pixel generation comes from an external combinational glyph decoder, so glyph size is no longer hard-wired.

Parameters:
- DIGITS_NUM, 6: number of BCD digits displayed (>=1).
- DIGIT_X_SIZE_PX, 21: glyph width in columns (>=1).
- LCD_X_SIZE_PX, 128: display width in columns.
- LCD_Y_SIZE_BYTES, 4: display height in 8-pixel pages (>=1).
- X_OFFSET_PX, 1: blank columns before first digit.
- Elaboration check: X_OFFSET_PX + DIGITS_NUM*DIGIT_X_SIZE_PX <= LCD_X_SIZE_PX, otherwise $error.

Ports:
- clk_in, in, 1: clock.
- reset_in, in, 1: synchronous active-high reset.
- digits_in, in, 4*DIGITS_NUM: BCD digits; MS digit in the top nibble.
- blank_lz_in, in, 1: leading-zero blanking enable, sampled with refresh.
- invert_in, in, 1: invert all frame bytes, sampled with refresh.
- refresh_stb_in, in, 1: start a frame; honoured only when ready_out=1.
- ready_out, out, 1: idle, accepts refresh.
- glyph_digit_out, out, 4: current digit value to the glyph decoder.
- glyph_x_out, out, $clog2(DIGIT_X_SIZE_PX) (min 1): column index within the glyph.
- glyph_y_out, out, $clog2(LCD_Y_SIZE_BYTES) (min 1): page index.
- glyph_pixels_in, in, 8: combinational decoder result for the above.
- oled_data_out, out, 8: byte to the driver.
- oled_write_stb_out, out, 1: data write strobe.
- oled_sync_stb_out, out, 1: end-of-frame sync strobe.
- oled_ready_in, in, 1: driver ready.

Behaviour:
- Clock and reset: one clock (clk_in). Reset (reset_in) is synchronous and active-high.
- During reset and the cycle after: state=S_RESET, all strobes 0, ready_out=0, counters 0, latched digits/flags 0.
- Reset mid-frame: aborts at once with no sync. The driver may see a truncated frame; a new refresh restarts from column 0.
- States: S_RESET -> S_IDLE.
- S_IDLE:
  - ready_out=1.
  - On refresh_stb_in: latch digits_in, blank_lz_in and invert_in; set col=0, page=0, leading=1; go to S_SEND_DATA.
  - refresh_stb_in is ignored in every other state.
- S_SEND_DATA:
  - oled_write_stb_out=1, held until oled_ready_in=0, then go to S_WAIT_FOR_READY.
  - oled_data_out is stable for the whole strobe.
- S_WAIT_FOR_READY: on oled_ready_in=1, advance the position and return to S_SEND_DATA. After the last byte (col=LCD_X_SIZE_PX-1, page=LCD_Y_SIZE_BYTES-1), go to S_SEND_SYNC instead.
- S_SEND_SYNC: oled_sync_stb_out=1 until oled_ready_in=0, then go to S_WAIT_FOR_SYNC.
- S_WAIT_FOR_SYNC: on oled_ready_in=1, go to S_IDLE.
- Position order:
  - page increments first; at LCD_Y_SIZE_BYTES-1, page wraps to 0 and col increments.
  - A separate digit counter (0 = MS digit) and glyph_x counter advance incrementally inside the digit field; no divider is used.
  - glyph_x wraps at DIGIT_X_SIZE_PX-1, then the digit counter increments.
- Column classes: col < X_OFFSET_PX is margin; the next DIGITS_NUM*DIGIT_X_SIZE_PX columns are digit fields; the rest is margin.
- Leading-zero blanking, evaluated on the first column of each digit field:
  - The digit is blank if blank_lz=1, leading=1, value=0, and it is not the last digit.
  - Any digit that is not blank clears leading.
  - The least-significant digit is always drawn.
- Byte value: margin or blank digit gives 0x00; a drawn digit gives glyph_pixels_in. The result is XORed with 0xFF when invert=1.
- glyph_digit_out carries the latched nibble of the current digit. glyph_* outputs are 0 in margins.
- Frame size: exactly LCD_X_SIZE_PX*LCD_Y_SIZE_BYTES write strobes, then 1 sync strobe.
- oled_ready_in held low: the FSM stalls indefinitely in the wait state with no strobe.
- Digits or flags changing mid-frame have no effect; latched values are used.

Test Plan (defaults unless noted):
- Reset, then refresh with digits_in=24'h123456, flags 0, driver model responding ready low 1 cycle then high → 512 writes then 1 sync, then ready_out=1. Bytes 0-3 are 0x00. Byte 4 has glyph_digit_out=1, glyph_x=0, glyph_y=0. Bytes 508-511 are 0x00.
- digits_in=24'h000120 with blank_lz=1 → bytes of digits 0-2 are 0x00. Digit 3 (=1) is drawn. Digit 5 (=0) is drawn, because leading was cleared.
- digits_in=24'h000000 with blank_lz=1 → only the last digit is drawn; all other bytes are 0x00.
- invert_in=1 with the glyph model returning 0x0F → digit bytes are 0xF0 and margin bytes are 0xFF.
- Driver holds oled_ready_in low 50 cycles mid-frame → no extra strobes and the byte count is unchanged. A refresh pulsed during the frame is ignored (exactly 512 writes).
- Reset asserted at byte 200 → next cycle both strobes are 0 and no sync is emitted. A new refresh restarts at col 0, page 0.
- DIGITS_NUM=2, DIGIT_X_SIZE_PX=8, LCD_X_SIZE_PX=20, LCD_Y_SIZE_BYTES=2, X_OFFSET_PX=2 → 40 writes. Digit columns are 2-17, glyph_x wraps at 7.

Source files
------------

// File: rtl/frame_streamer_if.sv
// OLED driver byte bus: data/write/sync strobes towards the driver, ready back from it.
`timescale 1ns/1ps
interface frame_streamer_if;
  logic [7:0] oled_data;
  logic       oled_write_stb;
  logic       oled_sync_stb;
  logic       oled_ready;

  modport master (output oled_data, output oled_write_stb, output oled_sync_stb, input oled_ready);
  modport slave  (input oled_data, input oled_write_stb, input oled_sync_stb, output oled_ready);
endinterface

// File: rtl/frame_streamer.sv
// Streams a column-major OLED frame: left margin, BCD glyph fields, right margin, then a sync strobe.
`timescale 1ns/1ps
module frame_streamer #(
  parameter int DIGITS_NUM       = 6,
  parameter int DIGIT_X_SIZE_PX  = 21,
  parameter int LCD_X_SIZE_PX    = 128,
  parameter int LCD_Y_SIZE_BYTES = 4,
  parameter int X_OFFSET_PX      = 1,
  localparam int GXW = (DIGIT_X_SIZE_PX > 1) ? $clog2(DIGIT_X_SIZE_PX) : 1,
  localparam int GYW = (LCD_Y_SIZE_BYTES > 1) ? $clog2(LCD_Y_SIZE_BYTES) : 1
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [4*DIGITS_NUM-1:0] digits_in,
  input  logic                    blank_lz_in,
  input  logic                    invert_in,
  input  logic                    refresh_stb_in,
  output logic                    ready_out,
  output logic [3:0]              glyph_digit_out,
  output logic [GXW-1:0]          glyph_x_out,
  output logic [GYW-1:0]          glyph_y_out,
  input  logic [7:0]              glyph_pixels_in,
  frame_streamer_if.master        oled_if
);

  localparam int CW       = (LCD_X_SIZE_PX > 1) ? $clog2(LCD_X_SIZE_PX) : 1;
  localparam int DGW      = $clog2(DIGITS_NUM + 1);
  localparam int FIELD_LO = X_OFFSET_PX;
  localparam int FIELD_HI = X_OFFSET_PX + DIGITS_NUM * DIGIT_X_SIZE_PX;

  if (FIELD_HI > LCD_X_SIZE_PX) begin : g_bad_geometry
    $error("frame_streamer: X_OFFSET_PX + DIGITS_NUM*DIGIT_X_SIZE_PX exceeds LCD_X_SIZE_PX");
  end

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_SEND_DATA, S_WAIT_FOR_READY, S_SEND_SYNC, S_WAIT_FOR_SYNC
  } state_t;

  state_t                  state_q;
  logic                    ready_q, wr_q, sync_q;
  logic [CW-1:0]           col_q, col_d;
  logic [GYW-1:0]          page_q, page_d;
  logic [GXW-1:0]          gx_q, gx_d;
  logic [DGW-1:0]          digit_q, digit_d;
  logic                    leading_q, leading_d;
  logic [4*DIGITS_NUM-1:0] digits_q;
  logic                    blz_q, inv_q;

  logic       in_field, digit_blank, last_byte;
  logic [3:0] cur_nib;
  logic [7:0] pix;

  assign in_field  = (int'(col_q) >= FIELD_LO) && (int'(col_q) < FIELD_HI);
  assign last_byte = (col_q == CW'(LCD_X_SIZE_PX - 1)) && (page_q == GYW'(LCD_Y_SIZE_BYTES - 1));

  always_comb begin
    cur_nib = 4'h0;
    for (int i = 0; i < DIGITS_NUM; i++) begin
      if (digit_q == DGW'(i)) cur_nib = digits_q[4*(DIGITS_NUM-1-i) +: 4];
    end
  end

  // leading only changes at digit boundaries, so the blank decision holds for the whole field
  assign digit_blank = blz_q && leading_q && (cur_nib == 4'h0) &&
                       (digit_q != DGW'(DIGITS_NUM - 1));

  // Next frame position: page first, then column; glyph column and digit step with the column
  always_comb begin
    col_d     = col_q;
    page_d    = page_q + 1'b1;
    gx_d      = gx_q;
    digit_d   = digit_q;
    leading_d = leading_q;
    if (page_q == GYW'(LCD_Y_SIZE_BYTES - 1)) begin
      page_d = '0;
      col_d  = col_q + 1'b1;
      if (in_field) begin
        if (gx_q == GXW'(DIGIT_X_SIZE_PX - 1)) begin
          gx_d    = '0;
          digit_d = digit_q + 1'b1;
          if (!digit_blank) leading_d = 1'b0;
        end else begin
          gx_d = gx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= S_RESET;
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      sync_q    <= 1'b0;
      col_q     <= '0;
      page_q    <= '0;
      gx_q      <= '0;
      digit_q   <= '0;
      leading_q <= 1'b0;
      digits_q  <= '0;
      blz_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        S_IDLE: begin
          if (refresh_stb_in) begin
            digits_q  <= digits_in;
            blz_q     <= blank_lz_in;
            inv_q     <= invert_in;
            col_q     <= '0;
            page_q    <= '0;
            gx_q      <= '0;
            digit_q   <= '0;
            leading_q <= 1'b1;
            ready_q   <= 1'b0;
            wr_q      <= 1'b1;
            state_q   <= S_SEND_DATA;
          end
        end
        S_SEND_DATA: begin
          if (!oled_if.oled_ready) begin
            wr_q    <= 1'b0;
            state_q <= S_WAIT_FOR_READY;
          end
        end
        S_WAIT_FOR_READY: begin
          if (oled_if.oled_ready) begin
            if (last_byte) begin
              sync_q  <= 1'b1;
              state_q <= S_SEND_SYNC;
            end else begin
              col_q     <= col_d;
              page_q    <= page_d;
              gx_q      <= gx_d;
              digit_q   <= digit_d;
              leading_q <= leading_d;
              wr_q      <= 1'b1;
              state_q   <= S_SEND_DATA;
            end
          end
        end
        S_SEND_SYNC: begin
          if (!oled_if.oled_ready) begin
            sync_q  <= 1'b0;
            state_q <= S_WAIT_FOR_SYNC;
          end
        end
        S_WAIT_FOR_SYNC: begin
          if (oled_if.oled_ready) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

  // Position registers are frozen during a strobe, so the byte stays stable while it is offered
  assign glyph_digit_out = in_field ? cur_nib : 4'h0;
  assign glyph_x_out     = in_field ? gx_q : '0;
  assign glyph_y_out     = in_field ? page_q : '0;
  assign pix             = (in_field && !digit_blank) ? glyph_pixels_in : 8'h00;

  assign oled_if.oled_data      = pix ^ {8{inv_q}};
  assign oled_if.oled_write_stb = wr_q;
  assign oled_if.oled_sync_stb  = sync_q;
  assign ready_out              = ready_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: a default-geometry and a small-geometry instance against a frame-level model.
`timescale 1ns/1ps
module tb_frame_streamer;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  frame_streamer_if if0 ();
  frame_streamer_if if1 ();

  logic [23:0] dig0 = '0;
  logic [7:0]  dig1 = '0;
  logic        blz0 = 0, blz1 = 0, inv0 = 0, inv1 = 0, refr0 = 0, refr1 = 0;
  logic        ready0, ready1;
  logic [3:0]  gd0, gd1;
  logic [4:0]  gx0;
  logic [2:0]  gx1;
  logic [1:0]  gy0;
  logic        gy1;
  logic [7:0]  gp0, gp1;
  bit          gconst = 0;

  logic        rdy[N];
  int          low[N];
  int          wcnt[N], scnt[N];
  int          stall_at[N];
  logic        rdy_prev[N];
  logic [23:0] e_dig[N];
  logic        e_blz[N], e_inv[N];
  int          cap_b[N][512], cap_d[N][512], cap_x[N][512], cap_y[N][512];

  // Per-instance views for the shared driver/checker loop
  logic        wr_w[N], sy_w[N], rd_w[N], blz_w[N], inv_w[N];
  logic [7:0]  dat_w[N], gx_w[N], gy_w[N];
  logic [3:0]  gd_w[N];
  logic [23:0] dig_w[N];

  const int nd_c[N] = '{6, 2};
  const int dx_c[N] = '{21, 8};
  const int lx_c[N] = '{128, 20};
  const int ly_c[N] = '{4, 2};
  const int xo_c[N] = '{1, 2};

  typedef struct packed {
    logic [7:0] b;
    logic [3:0] d;
    logic [7:0] x;
    logic [7:0] y;
  } exp_t;

  function automatic logic [7:0] gfun(int d, int x, int y, bit gc);
    if (gc) return 8'h0F;
    return 8'(d * 16 + x * 2 + y * 37) | 8'h01;
  endfunction

  assign gp0 = gfun(int'(gd0), int'(gx0), int'(gy0), gconst);
  assign gp1 = gfun(int'(gd1), int'(gx1), int'(gy1), gconst);

  assign if0.oled_ready = rdy[0];
  assign if1.oled_ready = rdy[1];

  assign wr_w[0] = if0.oled_write_stb;  assign wr_w[1] = if1.oled_write_stb;
  assign sy_w[0] = if0.oled_sync_stb;   assign sy_w[1] = if1.oled_sync_stb;
  assign dat_w[0] = if0.oled_data;      assign dat_w[1] = if1.oled_data;
  assign rd_w[0] = ready0;              assign rd_w[1] = ready1;
  assign gd_w[0] = gd0;                 assign gd_w[1] = gd1;
  assign gx_w[0] = 8'(gx0);             assign gx_w[1] = 8'(gx1);
  assign gy_w[0] = 8'(gy0);             assign gy_w[1] = 8'(gy1);
  assign dig_w[0] = dig0;               assign dig_w[1] = {16'h0, dig1};
  assign blz_w[0] = blz0;               assign blz_w[1] = blz1;
  assign inv_w[0] = inv0;               assign inv_w[1] = inv1;

  frame_streamer u0 (
    .clk_in(clk), .reset_in(rst), .digits_in(dig0), .blank_lz_in(blz0), .invert_in(inv0),
    .refresh_stb_in(refr0), .ready_out(ready0), .glyph_digit_out(gd0), .glyph_x_out(gx0),
    .glyph_y_out(gy0), .glyph_pixels_in(gp0), .oled_if(if0.master)
  );

  frame_streamer #(
    .DIGITS_NUM(2), .DIGIT_X_SIZE_PX(8), .LCD_X_SIZE_PX(20), .LCD_Y_SIZE_BYTES(2), .X_OFFSET_PX(2)
  ) u1 (
    .clk_in(clk), .reset_in(rst), .digits_in(dig1), .blank_lz_in(blz1), .invert_in(inv1),
    .refresh_stb_in(refr1), .ready_out(ready1), .glyph_digit_out(gd1), .glyph_x_out(gx1),
    .glyph_y_out(gy1), .glyph_pixels_in(gp1), .oled_if(if1.master)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Frame model: byte index -> column/page -> class -> value, from the display rules
  function automatic exp_t model(int idx, int i);
    exp_t e;
    int col, pg, dn, x, nib;
    bit blank;
    e   = '0;
    col = idx / ly_c[i];
    pg  = idx % ly_c[i];
    if (col >= xo_c[i] && col < xo_c[i] + nd_c[i] * dx_c[i]) begin
      dn    = (col - xo_c[i]) / dx_c[i];
      x     = (col - xo_c[i]) % dx_c[i];
      nib   = int'((e_dig[i] >> (4 * (nd_c[i] - 1 - dn))) & 24'hF);
      blank = e_blz[i] && (dn != nd_c[i] - 1);
      for (int k = 0; k <= dn; k++)
        if (((e_dig[i] >> (4 * (nd_c[i] - 1 - k))) & 24'hF) != 0) blank = 0;
      e.d = 4'(nib);
      e.x = 8'(x);
      e.y = 8'(pg);
      e.b = blank ? 8'h00 : gfun(nib, x, pg, gconst);
    end
    if (e_inv[i]) e.b = e.b ^ 8'hFF;
    return e;
  endfunction

  // Driver model and per-byte comparison
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      exp_t e;
      if (rdy_prev[i] && !rd_w[i] && !rst) begin
        wcnt[i]  = 0;
        scnt[i]  = 0;
        e_dig[i] = dig_w[i];
        e_blz[i] = blz_w[i];
        e_inv[i] = inv_w[i];
      end
      if (wr_w[i] && sy_w[i]) chk("both_strobes", 1, 0);
      if (!rdy[i]) begin
        if (low[i] > 0) low[i]--;
        if (low[i] == 0) rdy[i] = 1'b1;
      end else if (wr_w[i]) begin
        e = model(wcnt[i], i);
        chk("byte", 32'(dat_w[i]), 32'(e.b));
        chk("glyph_digit", 32'(gd_w[i]), 32'(e.d));
        chk("glyph_x", 32'(gx_w[i]), 32'(e.x));
        chk("glyph_y", 32'(gy_w[i]), 32'(e.y));
        if (wcnt[i] < 512) begin
          cap_b[i][wcnt[i]] = int'(dat_w[i]);
          cap_d[i][wcnt[i]] = int'(gd_w[i]);
          cap_x[i][wcnt[i]] = int'(gx_w[i]);
          cap_y[i][wcnt[i]] = int'(gy_w[i]);
        end
        wcnt[i]++;
        rdy[i] = 1'b0;
        low[i] = (wcnt[i] == stall_at[i]) ? 50 : 1;
      end else if (sy_w[i]) begin
        scnt[i]++;
        rdy[i] = 1'b0;
        low[i] = 1;
      end
      rdy_prev[i] = rd_w[i];
    end
  end

  task automatic wait_ready(int i);
    int t = 0;
    while (!rd_w[i] && t < 200) begin @(negedge clk); #1; t++; end
    chk("ready_wait", 32'(rd_w[i]), 1);
  endtask

  task automatic run_frame(int i, logic [23:0] dig, bit b, bit v, bit gc, int stall, bit pulse);
    int t = 0;
    int w;
    stall_at[i] = stall;
    gconst = gc;
    wait_ready(i);
    @(negedge clk); #1;
    if (i == 0) begin dig0 = dig; blz0 = b; inv0 = v; refr0 = 1; end
    else begin dig1 = dig[7:0]; blz1 = b; inv1 = v; refr1 = 1; end
    @(negedge clk); #1;
    if (i == 0) begin refr0 = 0; dig0 = ~dig; blz0 = ~b; inv0 = ~v; end
    else begin refr1 = 0; dig1 = ~dig[7:0]; blz1 = ~b; inv1 = ~v; end
    while (!(scnt[i] == 1 && rd_w[i]) && t < 5000) begin
      @(negedge clk); #1;
      t++;
      if (pulse) begin
        if (t == 300) begin if (i == 0) refr0 = 1; else refr1 = 1; end
        if (t == 301) begin if (i == 0) refr0 = 0; else refr1 = 0; end
      end
    end
    chk("frame_done", 32'(t < 5000), 1);
    chk("write_count", 32'(wcnt[i]), 32'(lx_c[i] * ly_c[i]));
    chk("sync_count", 32'(scnt[i]), 1);
    w = wcnt[i];
    repeat (10) @(negedge clk);
    #1;
    chk("no_extra_writes", 32'(wcnt[i]), 32'(w));
  endtask

  initial begin
    int t;
    for (int i = 0; i < N; i++) begin
      rdy[i] = 1'b1; low[i] = 0; wcnt[i] = 0; scnt[i] = 0; stall_at[i] = -1;
      rdy_prev[i] = 1'b0; e_dig[i] = '0; e_blz[i] = 0; e_inv[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready0), 0);
    chk("rst_write", 32'(if0.oled_write_stb), 0);
    chk("rst_sync", 32'(if0.oled_sync_stb), 0);
    chk("rst_data", 32'(if0.oled_data), 0);
    chk("rst_glyph", 32'({gd0, gx0, gy0}), 0);
    chk("rst_ready_small", 32'(ready1), 0);
    rst = 1'b0;

    // Plain frame
    run_frame(0, 24'h123456, 0, 0, 0, -1, 0);
    chk("a_byte0", cap_b[0][0], 0);
    chk("a_byte3", cap_b[0][3], 0);
    chk("a_b4_digit", cap_d[0][4], 1);
    chk("a_b4_x", cap_x[0][4], 0);
    chk("a_b4_y", cap_y[0][4], 0);
    chk("a_b4_val", cap_b[0][4], 32'h11);
    chk("a_b5_val", cap_b[0][5], 32'h35);
    chk("a_b88_digit", cap_d[0][88], 2);
    chk("a_b508", cap_b[0][508], 0);
    chk("a_b511", cap_b[0][511], 0);

    // Leading-zero blanking
    run_frame(0, 24'h000120, 1, 0, 0, -1, 0);
    chk("b_d0", cap_b[0][4], 0);
    chk("b_d2", cap_b[0][172], 0);
    chk("b_d3", cap_b[0][256], 32'h11);
    chk("b_d4", cap_b[0][340], 32'h21);
    chk("b_d5", cap_b[0][424], 32'h01);

    run_frame(0, 24'h000000, 1, 0, 0, -1, 0);
    chk("c_d4_last_col", cap_b[0][420], 0);
    chk("c_d5", cap_b[0][424], 32'h01);

    // Inversion with a constant glyph
    run_frame(0, 24'h123456, 0, 1, 1, -1, 0);
    chk("d_margin", cap_b[0][0], 32'hFF);
    chk("d_digit", cap_b[0][4], 32'hF0);

    // Long driver stall plus an ignored mid-frame refresh
    run_frame(0, 24'h987654, 0, 0, 0, 100, 1);

    // Reset in the middle of a frame
    stall_at[0] = -1;
    wait_ready(0);
    @(negedge clk); #1;
    dig0 = 24'h111111; refr0 = 1;
    @(negedge clk); #1;
    refr0 = 0;
    t = 0;
    while (wcnt[0] < 200 && t < 2000) begin @(negedge clk); #1; t++; end
    chk("e_reached_200", 32'(wcnt[0]), 200);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("e_rst_write", 32'(if0.oled_write_stb), 0);
    chk("e_rst_sync", 32'(if0.oled_sync_stb), 0);
    chk("e_rst_ready", 32'(ready0), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("e_no_sync", 32'(scnt[0]), 0);
    chk("e_no_writes", 32'(wcnt[0]), 200);
    run_frame(0, 24'h654321, 0, 0, 0, -1, 0);
    chk("e_restart_digit", cap_d[0][4], 6);
    chk("e_restart_val", cap_b[0][4], 32'h61);
    chk("e_restart_b0", cap_b[0][0], 0);

    // Small geometry instance
    run_frame(1, 24'h000037, 0, 0, 0, -1, 0);
    chk("s_b3", cap_b[1][3], 0);
    chk("s_b4_val", cap_b[1][4], 32'h31);
    chk("s_b20_digit", cap_d[1][20], 7);
    chk("s_b20_x", cap_x[1][20], 0);
    chk("s_b35_x", cap_x[1][35], 7);
    chk("s_b35_val", cap_b[1][35], 32'hA3);
    chk("s_b36", cap_b[1][36], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
